// File: rtl/tug_ctrl.sv
// tug_ctrl: tug-of-war game controller feeding the LED mux.
// Syncs buttons, moves the rope, detects wins and times the win flash.
module tug_ctrl #(
  parameter int FLASH_CYC     = 25000000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic [1:0] leds_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner
);

  localparam int PW = $clog2(FLASH_CYC + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(FLASH_CYC - 1);
  localparam logic [TW-1:0] TG_LAST = TW'(FLASH_TOGGLES - 1);
  localparam logic [6:0] CENTRE = 7'b0001000;
  localparam logic [6:0] L_END  = 7'b1000000;
  localparam logic [6:0] R_END  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    WIN,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    sl;
  logic [2:0]    sr;
  logic [PW-1:0] phase;
  logic [TW-1:0] tog;
  logic          pul_l;
  logic          pul_r;
  logic          pl;
  logic          pr;
  logic          any;

  // [0]/[1] synchronise, [2] holds the previous synced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl <= '0;
      sr <= '0;
    end else begin
      sl <= {sl[1:0], pbl};
      sr <= {sr[1:0], pbr};
    end
  end

  assign pul_l = sl[1] & ~sl[2];
  assign pul_r = sr[1] & ~sr[2];
  assign pl    = pul_l & ~pul_r;
  assign pr    = pul_r & ~pul_l;
  assign any   = pl | pr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      leds_ctrl <= 2'd1;
      score     <= CENTRE;
      winner    <= 2'b00;
      phase     <= '0;
      tog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state     <= PLAY;
            leds_ctrl <= 2'd2;
          end
        end
        PLAY: begin
          unique case (1'b1)
            pl: begin
              if (score == L_END) begin
                state     <= WIN;
                winner    <= 2'b01;
                leds_ctrl <= 2'd3;
                phase     <= '0;
                tog       <= '0;
              end else begin
                score <= score << 1;
              end
            end
            pr: begin
              if (score == R_END) begin
                state     <= WIN;
                winner    <= 2'b10;
                leds_ctrl <= 2'd3;
                phase     <= '0;
                tog       <= '0;
              end else begin
                score <= score >> 1;
              end
            end
            default: ;
          endcase
        end
        WIN: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            tog   <= tog + TW'(1);
            if (tog == TG_LAST) begin
              state     <= DONE;
              leds_ctrl <= 2'd2;
            end else begin
              leds_ctrl <= (leds_ctrl == 2'd3) ? 2'd0 : 2'd3;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          if (any) begin
            state     <= IDLE;
            score     <= CENTRE;
            winner    <= 2'b00;
            leds_ctrl <= 2'd1;
          end
        end
        default: begin
          state     <= IDLE;
          leds_ctrl <= 2'd1;
          score     <= CENTRE;
          winner    <= 2'b00;
          phase     <= '0;
          tog       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_ctrl.sv
// tb_tug_ctrl: scoreboard bench for tug_ctrl with a game-level model.
// Directed test plan followed by randomized button traffic.
module tb_tug_ctrl;

  localparam int FC = 4;
  localparam int FT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic [1:0] leds_ctrl;
  logic [6:0] score;
  logic [1:0] winner;

  tug_ctrl #(
    .FLASH_CYC    (FC),
    .FLASH_TOGGLES(FT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pbl      (pbl),
    .pbr      (pbr),
    .leds_ctrl(leds_ctrl),
    .score    (score),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] leds;
    logic [6:0] score;
    logic [1:0] win;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // game model: mode 0 idle, 1 play, 2 win, 3 done; pos +3 = left end
  int m_mode = 0;
  int m_pos  = 0;
  int m_win  = 0;
  int m_wt   = 0;
  // button levels seen at the last three edges (1 = newest)
  bit hl1, hl2, hl3, hr1, hr2, hr3;

  function automatic exp_t m_out();
    exp_t e;
    case (m_mode)
      0:       e.leds = 2'd1;
      1:       e.leds = 2'd2;
      2:       e.leds = ((m_wt / FC) % 2 == 0) ? 2'd3 : 2'd0;
      default: e.leds = 2'd2;
    endcase
    e.score = 7'(1 << (3 + m_pos));
    e.win   = 2'(m_win);
    return e;
  endfunction

  task automatic m_step(input bit l, input bit r, input bit rn);
    bit pul, pur, a, b;
    if (!rn) begin
      m_mode = 0; m_pos = 0; m_win = 0; m_wt = 0;
      {hl1, hl2, hl3, hr1, hr2, hr3} = '0;
    end else begin
      // a rise sampled at edge k acts at edge k+2
      pul = hl2 & !hl3;
      pur = hr2 & !hr3;
      a   = pul & !pur;
      b   = pur & !pul;
      case (m_mode)
        0: if (a || b) m_mode = 1;
        1: begin
          if (a) begin
            if (m_pos == 3) begin
              m_mode = 2; m_win = 1; m_wt = 0;
            end else m_pos++;
          end else if (b) begin
            if (m_pos == -3) begin
              m_mode = 2; m_win = 2; m_wt = 0;
            end else m_pos--;
          end
        end
        2: begin
          m_wt++;
          if (m_wt >= FC * FT) m_mode = 3;
        end
        default: begin
          if (a || b) begin
            m_mode = 0; m_pos = 0; m_win = 0;
          end
        end
      endcase
      hl3 = hl2; hl2 = hl1; hl1 = l;
      hr3 = hr2; hr2 = hr1; hr1 = r;
    end
    q.push_back(m_out());
  endtask

  task automatic cycle(input bit l, input bit r, input bit rn);
    @(negedge clk);
    pbl = l;
    pbr = r;
    rst = rn;
    m_step(l, r, rn);
  endtask

  task automatic press(input bit l, input bit r);
    cycle(l, r, 1'b1);
    cycle(l, r, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (e.leds !== leds_ctrl || e.score !== score || e.win !== winner) begin
          fails++;
          $display("FAIL scoreboard t=%0t leds=%0d exp %0d score=%b exp %b winner=%b exp %b",
                   $time, leds_ctrl, e.leds, score, e.score, winner, e.win);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit vl, vr, rn;
    rst = 1'b0;
    pbl = 1'b0;
    pbr = 1'b0;
    for (int i = 0; i < 6; i++) cycle(i[0], i[1], 1'b0);
    settle();
    check("rst_leds", leds_ctrl, 2'd1);
    check("rst_score", score, 7'b0001000);
    check("rst_winner", winner, 2'b00);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    settle();
    check("release_leds", leds_ctrl, 2'd1);

    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    settle();
    check("start_k1_leds", leds_ctrl, 2'd1);
    cycle(1'b1, 1'b0, 1'b1);
    settle();
    check("start_k2_leds", leds_ctrl, 2'd2);
    check("start_k2_score", score, 7'b0001000);
    repeat (20) cycle(1'b1, 1'b0, 1'b1);
    settle();
    check("hold_leds", leds_ctrl, 2'd2);
    check("hold_score", score, 7'b0001000);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    repeat (3) press(1'b1, 1'b0);
    settle();
    check("move_left3", score, 7'b1000000);
    press(1'b0, 1'b1);
    settle();
    check("move_right1", score, 7'b0100000);

    #1;
    rst = 1'b0;
    #1;
    check("async_rst_leds", leds_ctrl, 2'd1);
    check("async_rst_score", score, 7'b0001000);
    check("async_rst_winner", winner, 2'b00);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);

    press(1'b1, 1'b0);
    settle();
    check("restart_play", leds_ctrl, 2'd2);
    press(1'b1, 1'b1);
    settle();
    check("simul_score", score, 7'b0001000);
    check("simul_leds", leds_ctrl, 2'd2);

    repeat (3) press(1'b0, 1'b1);
    settle();
    check("right_end", score, 7'b0000001);
    press(1'b0, 1'b1);
    settle();
    check("rwin_winner", winner, 2'b10);
    check("rwin_leds", leds_ctrl, 2'd3);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b1);
    settle();
    check("done_leds", leds_ctrl, 2'd2);
    check("done_score", score, 7'b0000001);
    check("done_winner", winner, 2'b10);

    press(1'b1, 1'b0);
    settle();
    check("idle_leds", leds_ctrl, 2'd1);
    check("idle_score", score, 7'b0001000);
    check("idle_winner", winner, 2'b00);
    press(1'b1, 1'b0);
    settle();
    check("replay_leds", leds_ctrl, 2'd2);

    repeat (4) press(1'b1, 1'b0);
    settle();
    check("lwin_winner", winner, 2'b01);
    check("lwin_score", score, 7'b1000000);
    repeat (12) cycle(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1);
    settle();
    check("lwin_restart", leds_ctrl, 2'd1);

    vl = 1'b0;
    vr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) vl = !vl;
      if ($urandom_range(0, 2) == 0) vr = !vr;
      rn = ($urandom_range(0, 599) != 0);
      cycle(vl, vr, rn);
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tug_ctrl.md
Name: tug_ctrl

Overview:
- Game controller for the tug-of-war design; sits directly upstream of the LED multiplexer.
- Takes the two player push-buttons and produces the `leds_ctrl[1:0]` mode code and the `score[6:0]` one-hot rope position that the mux consumes.
- Owns button synchronisation, rising-edge detection, rope movement, win detection, win-flash timing and restart sequencing.

Parameters:
- FLASH_CYC, 25000000, clock cycles per on/off phase while flashing a win (must be >= 1).
- FLASH_TOGGLES, 6, number of flash phases before the win display settles (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- pbl  input  1  left player button, asynchronous, active-high.
- pbr  input  1  right player button, asynchronous, active-high.
- leds_ctrl  output  2  mode code to the LED mux: 0 = off, 1 = "sn" idle pattern, 2 = show score, 3 = all on. Registered.
- score  output  7  one-hot rope position; bit 3 is centre, bit 6 is the left end. Registered.
- winner  output  2  00 = none, 01 = left, 10 = right. Registered.

Behaviour:
- Reset (rst = 0, asynchronous, any state, including mid-flash) forces:
  - state IDLE; leds_ctrl = 1; score = 7'b0001000; winner = 00.
  - all counters, synchroniser flops and edge registers cleared.
- Button path, per button:
  - 2-flop synchroniser s1 -> s2, then a previous-value flop s3.
  - pulse = s2 & ~s3, high for exactly one cycle per rising edge; holding a button produces no further pulses.
  - Latency: a button rising before edge k (its first sampling edge) causes its pulse to take effect at edge k+2.
- Simultaneous pulses: pl = pulse_l & ~pulse_r and pr = pulse_r & ~pulse_l. Both in the same cycle means no action in every state.
- State IDLE:
  - leds_ctrl = 1; score held at centre.
  - pl or pr -> PLAY with leds_ctrl = 2. The starting press does not move the rope.
- State PLAY (leds_ctrl = 2):
  - pl with score != 7'b1000000: score <= score << 1.
  - pr with score != 7'b0000001: score <= score >> 1.
  - pl with score == 7'b1000000: -> WIN, winner <= 01, score unchanged.
  - pr with score == 7'b0000001: -> WIN, winner <= 10, score unchanged.
  - Pressing away from an end moves normally; for example, pr at bit 6 moves the rope to bit 5.
  - score is always exactly one-hot.
- State WIN:
  - Entry sets leds_ctrl = 3, phase counter = 0, toggle counter = 0.
  - After FLASH_CYC cycles in a phase: leds_ctrl alternates 3 <-> 0, the phase counter resets and the toggle counter increments.
  - When the toggle counter reaches FLASH_TOGGLES: -> DONE with leds_ctrl = 2.
  - All button pulses are ignored in WIN.
- State DONE:
  - leds_ctrl = 2; score shows the winner's end bit; winner held.
  - pl or pr -> IDLE: score <= 7'b0001000, winner <= 00, leds_ctrl <= 1.
- Undefined state encodings recover to IDLE on the next edge.
- Counter widths: $clog2(FLASH_CYC+1) and $clog2(FLASH_TOGGLES+1) bits. Neither counter wraps.

Test Plan (FLASH_CYC = 4, FLASH_TOGGLES = 2):
- Reset: hold rst = 0 with buttons toggling, release -> leds_ctrl = 1, score = 0001000, winner = 00; assert rst = 0 mid-PLAY -> same values immediately, without waiting for a clock edge.
- Start and latency: pbl rises just before edge k -> leds_ctrl = 2 after edge k+2, score still 0001000. Then hold pbl high 20 cycles -> no further change.
- Movement: in PLAY, 3 separate pbl presses -> score 1000000; 1 pbr press -> 0100000.
- Simultaneous: in PLAY at 0001000, pbl and pbr rise in the same cycle -> score unchanged, state PLAY.
- Right win and flash: from 0000001, pbr press -> winner = 10; leds_ctrl = 3 for 4 cycles, 0 for 4 cycles, then 2 with score = 0000001. Presses during the flash are ignored.
- Restart: in DONE, press pbl -> IDLE (leds_ctrl = 1, score = 0001000, winner = 00). A second press enters PLAY.
